// File: rtl/async_queue_sink_d1.sv
// async_queue_sink_d1: destination-domain end of a depth-1 async crossing queue
// that carries TileLink D-channel beats.
// It synchronizes the source write index and exports a gray read index.
// It presents the stored beat on a ready/valid dequeue port.
// It runs the alive/reset handshake so that either side can reset on its own.
//
// Ports
//   clock, reset                      sink clock, async active-high reset
//   io_deq_ready / io_deq_valid       dequeue handshake
//   io_deq_bits_*                     dequeued beat (held when not loading)
//   io_async_mem_0_*                  source-domain storage slot (quasi-static)
//   io_async_widx                     source write index (gray == binary, 1 bit)
//   io_async_ridx                     registered read index back to the source
//   io_async_safe_widx_valid          source alive indication
//   io_async_safe_source_reset_n      source reset, active-low
//   io_async_safe_ridx_valid          sink alive indication
//   io_async_safe_sink_reset_n        ~reset

module async_queue_sink_d1 (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_deq_ready,
    output logic        io_deq_valid,
    output logic [2:0]  io_deq_bits_opcode,
    output logic [1:0]  io_deq_bits_param,
    output logic [1:0]  io_deq_bits_size,
    output logic        io_deq_bits_source,
    output logic        io_deq_bits_sink,
    output logic        io_deq_bits_denied,
    output logic [31:0] io_deq_bits_data,
    output logic        io_deq_bits_corrupt,
    input  logic [2:0]  io_async_mem_0_opcode,
    input  logic [1:0]  io_async_mem_0_param,
    input  logic [1:0]  io_async_mem_0_size,
    input  logic        io_async_mem_0_source,
    input  logic        io_async_mem_0_sink,
    input  logic        io_async_mem_0_denied,
    input  logic [31:0] io_async_mem_0_data,
    input  logic        io_async_mem_0_corrupt,
    input  logic        io_async_widx,
    output logic        io_async_ridx,
    input  logic        io_async_safe_widx_valid,
    input  logic        io_async_safe_source_reset_n,
    output logic        io_async_safe_ridx_valid,
    output logic        io_async_safe_sink_reset_n
);

    localparam int unsigned SYNC_DEPTH = 3;

    // Chains that must clear when either side resets
    logic source_reset;
    assign source_reset = reset | ~io_async_safe_source_reset_n;

    logic [SYNC_DEPTH-1:0] widx_sync_q;
    logic [SYNC_DEPTH-1:0] sink_valid_0_q;
    logic [SYNC_DEPTH-1:0] sink_valid_1_q;
    logic [SYNC_DEPTH-1:0] source_extend_q;
    logic [SYNC_DEPTH-1:0] source_valid_q;

    logic widx_sync;
    logic source_ready;
    logic ridx_bin;
    logic ridx_next;
    logic valid_reg;
    logic valid_next;
    logic deq_fire;
    logic ridx_reg;

    // Write index synchronizer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) widx_sync_q <= '0;
        else       widx_sync_q <= {widx_sync_q[SYNC_DEPTH-2:0], io_async_widx};
    end

    // Sink alive chains, cleared by either reset
    always_ff @(posedge clock or posedge source_reset) begin
        if (source_reset) begin
            sink_valid_0_q  <= '0;
            sink_valid_1_q  <= '0;
            source_extend_q <= '0;
        end else begin
            sink_valid_0_q  <= {sink_valid_0_q[SYNC_DEPTH-2:0], 1'b1};
            sink_valid_1_q  <= {sink_valid_1_q[SYNC_DEPTH-2:0], sink_valid_0_q[SYNC_DEPTH-1]};
            source_extend_q <= {source_extend_q[SYNC_DEPTH-2:0], io_async_safe_widx_valid};
        end
    end

    // Source-valid stage is reset by the local reset only, so a source reset
    // takes a full synchronizer depth to reach source_ready
    always_ff @(posedge clock or posedge reset) begin
        if (reset) source_valid_q <= '0;
        else       source_valid_q <= {source_valid_q[SYNC_DEPTH-2:0], source_extend_q[SYNC_DEPTH-1]};
    end

    assign widx_sync    = widx_sync_q[SYNC_DEPTH-1];
    assign source_ready = source_valid_q[SYNC_DEPTH-1];

    // Read pointer and valid next-state; losing the source forces the pointer home
    assign deq_fire   = io_deq_valid & io_deq_ready;
    assign ridx_next  = source_ready ? (ridx_bin ^ deq_fire) : 1'b0;
    assign valid_next = source_ready & (ridx_next != widx_sync);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ridx_bin  <= 1'b0;
            valid_reg <= 1'b0;
            ridx_reg  <= 1'b0;
        end else begin
            ridx_bin  <= ridx_next;
            valid_reg <= valid_next;
            ridx_reg  <= ridx_next;
        end
    end

    // Beat register: reloads from the slot while a beat is pending, holds otherwise
    always_ff @(posedge clock) begin
        if (valid_next) begin
            io_deq_bits_opcode  <= io_async_mem_0_opcode;
            io_deq_bits_param   <= io_async_mem_0_param;
            io_deq_bits_size    <= io_async_mem_0_size;
            io_deq_bits_source  <= io_async_mem_0_source;
            io_deq_bits_sink    <= io_async_mem_0_sink;
            io_deq_bits_denied  <= io_async_mem_0_denied;
            io_deq_bits_data    <= io_async_mem_0_data;
            io_deq_bits_corrupt <= io_async_mem_0_corrupt;
        end
    end

    // Valid is gated combinationally so a source loss drops it without a clock
    assign io_deq_valid               = valid_reg & source_ready;
    assign io_async_ridx              = ridx_reg;
    assign io_async_safe_ridx_valid   = sink_valid_1_q[SYNC_DEPTH-1];
    assign io_async_safe_sink_reset_n = ~reset;

endmodule

// File: doc/async_queue_sink_d1.md
# async_queue_sink_d1

Receive end of the depth-1 asynchronous clock-crossing queue carrying TileLink D-channel-style beats (opcode/param/size/source/sink/denied/data/corrupt). The block sits in the destination clock domain and pairs with the depth-1 queue source in the other domain. It synchronizes the source's write index and exports a gray read index. It presents entries as a registered ready/valid dequeue port and runs the reset/valid handshake that lets either side reset independently.

## Interface
- No parameters; depth 1 (1-bit index, gray == binary), synchronizer depth 3 fixed.
- clock  in  1  sink-domain clock
- reset  in  1  asynchronous, active-high
- io_deq_ready  in  1  consumer accepts beat
- io_deq_valid  out  1  beat available
- io_deq_bits_opcode/param/size/source/sink/denied/data/corrupt  out  3/2/2/1/1/1/32/1  dequeued beat
- io_async_mem_0_opcode/param/size/source/sink/denied/data/corrupt  in  3/2/2/1/1/1/32/1  source-domain storage slot (quasi-static)
- io_async_widx  in  1  source write index (gray), source clock domain
- io_async_ridx  out  1  registered read index (gray)
- io_async_safe_widx_valid  in  1  source alive indication
- io_async_safe_source_reset_n  in  1  source reset, active-low
- io_async_safe_ridx_valid  out  1  sink alive indication
- io_async_safe_sink_reset_n  out  1  equals ~reset

## Operation
- widx_sync: 3-flop async-reset synchronizer of io_async_widx, reset 0, reset by reset only.
- valid-sync chains, each a 3-flop async-reset synchronizer with reset value 0:
  - sink_valid_0: d=1, reset = reset | ~io_async_safe_source_reset_n.
  - sink_valid_1: d=sink_valid_0, same reset. Its output drives io_async_safe_ridx_valid.
  - source_extend: d=io_async_safe_widx_valid, reset = reset | ~io_async_safe_source_reset_n.
  - source_valid: d=source_extend, reset = reset only. Its output is source_ready.
- ridx_bin: 1-bit register, async reset 0.
  - ridx_next = source_ready ? ridx_bin ^ deq_fire : 0.
  - deq_fire = io_deq_valid & io_deq_ready.
  - ridx_bin <= ridx_next.
- valid_next = source_ready & (ridx_next != widx_sync).
- valid_reg <= valid_next (async reset 0).
- io_deq_valid = valid_reg & source_ready. The AND is combinational, so a source loss drops valid in the same cycle.
- bits register (no reset) loads all io_async_mem_0_* fields when valid_next=1 and holds otherwise. Depth 1, so the slot is always mem_0.
- ridx_reg <= ridx_next (async reset 0) drives io_async_ridx.
- io_async_safe_sink_reset_n = ~reset, combinational.
- Source reset while the source is not ready:
  - source_ready=0 forces ridx_bin and ridx_reg to 0 and deq_valid to 0.
  - A pending beat is discarded.
  - Consumer-side io_deq_bits holds its last value.
- Simultaneous events:
  - A fire in the cycle source_ready falls is ignored, because ridx forces to 0.
  - A widx toggle arriving in the same cycle as a fire is seen via widx_sync on later cycles.

## Timing
- Reset values:
  - io_deq_valid 0, io_async_ridx 0, io_async_safe_ridx_valid 0, io_async_safe_sink_reset_n 0 during reset.
  - io_deq_bits undefined until first load.
- Bring-up after reset deassertion, with safe_widx_valid=1 and source_reset_n=1 held:
  - io_async_safe_ridx_valid rises after 6 clock edges.
  - source_ready rises after 6 edges.
- Write latency: an io_async_widx toggle stable before edge N reaches widx_sync after edges N..N+2 (output at N+2). valid_reg and bits load at N+3. io_deq_valid=1 after edge N+3.
- Pop: a fire at edge M toggles ridx_bin and io_async_ridx at M, and io_deq_valid=0 after M (ridx==widx).
- Throughput is bounded by the source round trip: at most one beat per cross-domain handshake.
- The mem_0 fields must be stable whenever widx_sync != ridx_bin; the source guarantees this.
- Loss of source:
  - Asserting io_async_safe_source_reset_n=0 clears source_extend asynchronously.
  - source_ready falls 3 edges later.
  - io_deq_valid drops combinationally with it.

## Test plan
- Reset, then hold safe_widx_valid=1 and source_reset_n=1 -> safe_ridx_valid and internal ready rise on edge 6, deq_valid stays 0, ridx=0, sink_reset_n=1.
- After bring-up, set mem_0 data=0xDEADBEEF, opcode=1, size=2, then toggle widx 0->1 -> deq_valid=1 exactly 4 edges later with bits matching, held while deq_ready=0.
- Pulse deq_ready=1 for one cycle -> ridx toggles to 1 and deq_valid=0 the next cycle. Then toggle widx to 0 with data=0x12345678 -> second beat delivered, and ridx returns to 0 on its pop.
- With a beat pending, drive source_reset_n=0 -> deq_valid falls 3 edges later, ridx forced to 0, safe_ridx_valid=0. Release -> ready returns after 6 edges and no stale beat appears with widx=0.
- Assert reset mid-beat (deq_valid=1) -> deq_valid, ridx and sink_reset_n go 0 immediately and asynchronously, without waiting for a clock edge.
